// File: rtl/dm_cache_mem_system_pkg.sv
// Shared widths, address field slices and FSM state encoding for the
// direct-mapped cache memory system.
package mem_sys_pkg;

  localparam int unsigned ADDR_W     = 32;
  localparam int unsigned DATA_W     = 32;
  localparam int unsigned LINE_WORDS = 4;
  localparam int unsigned SETS       = 64;
  localparam int unsigned MEM_LAT    = 2;

  localparam int unsigned OFF_LSB = 2;
  localparam int unsigned OFF_MSB = 3;
  localparam int unsigned IDX_LSB = 4;
  localparam int unsigned IDX_MSB = 9;
  localparam int unsigned TAG_LSB = 10;
  localparam int unsigned TAG_MSB = 17;

  localparam int unsigned OFF_W  = OFF_MSB - OFF_LSB + 1;
  localparam int unsigned IDX_W  = IDX_MSB - IDX_LSB + 1;
  localparam int unsigned TAG_W  = TAG_MSB - TAG_LSB + 1;
  localparam int unsigned MEM_AW = TAG_MSB - OFF_LSB + 1;

  localparam logic [OFF_W-1:0] LAST_WORD = OFF_W'(LINE_WORDS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WB,
    S_FILL_REQ,
    S_FILL_WAIT,
    S_INSTALL,
    S_COMPLETE
  } state_t;

  function automatic logic [MEM_AW-1:0] word_addr(input logic [TAG_W-1:0] tag,
                                                  input logic [IDX_W-1:0] idx,
                                                  input logic [OFF_W-1:0] off);
    return {tag, idx, off};
  endfunction

endpackage

// File: rtl/dm_cache_mem_system_if.sv
// Requester-side load/store bus of the cache memory system.
interface dm_cache_mem_system_if;
  import mem_sys_pkg::*;

  logic [ADDR_W-1:0] Addr;
  logic [DATA_W-1:0] DataIn;
  logic              Rd;
  logic              Wr;
  logic              createdump;
  logic [DATA_W-1:0] DataOut;
  logic              Done;
  logic              Stall;
  logic              CacheHit;

  modport master (
    output Addr, DataIn, Rd, Wr, createdump,
    input  DataOut, Done, Stall, CacheHit
  );

  modport slave (
    input  Addr, DataIn, Rd, Wr, createdump,
    output DataOut, Done, Stall, CacheHit
  );

endinterface

// File: rtl/dm_cache_mem_system_main_mem.sv
// Main-memory model: one read or write per cycle, reads return LAT cycles
// later with a valid strobe. Contents are never reset.
module main_mem_model
  import mem_sys_pkg::*;
#(
  parameter int unsigned LAT = MEM_LAT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              req_write,
  input  logic [MEM_AW-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data
);

  logic [DATA_W-1:0] mem [2**MEM_AW];
  logic [LAT-1:0]    pipe_valid;
  logic [DATA_W-1:0] pipe_data [LAT];

  always_ff @(posedge clk) begin
    if (req_valid && req_write) begin
      mem[req_addr] <= req_wdata;
    end
  end

  // Reset only flushes in-flight returns; stored words survive.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pipe_valid <= '0;
      pipe_data  <= '{default: '0};
    end else begin
      pipe_valid[0] <= req_valid && !req_write;
      pipe_data[0]  <= mem[req_addr];
      for (int unsigned k = 1; k < LAT; k++) begin
        pipe_valid[k] <= pipe_valid[k-1];
        pipe_data[k]  <= pipe_data[k-1];
      end
    end
  end

  always_comb begin
    rsp_valid = pipe_valid[LAT-1];
    rsp_data  = pipe_data[LAT-1];
  end

endmodule

// File: rtl/dm_cache_mem_system.sv
// Direct-mapped write-back, write-allocate cache in front of a pipelined
// main-memory model; hits complete in the request cycle.
module dm_cache_mem_system
  import mem_sys_pkg::*;
#(
  parameter int unsigned LAT = MEM_LAT
) (
  input  logic                  clk,
  input  logic                  rst,
  dm_cache_mem_system_if.slave  bus
);

  state_t            state;
  logic [OFF_W-1:0]  cnt;
  logic [OFF_W-1:0]  rsp_cnt;
  logic [SETS-1:0]   valid;
  logic [SETS-1:0]   dirty;
  logic [TAG_W-1:0]  tag_arr  [SETS];
  logic [DATA_W-1:0] data_arr [SETS][LINE_WORDS];

  logic [OFF_W-1:0]  off;
  logic [IDX_W-1:0]  idx;
  logic [TAG_W-1:0]  tag;
  logic              req;
  logic              hit;
  logic [DATA_W-1:0] line_word;

  logic              mem_req_valid;
  logic              mem_req_write;
  logic [MEM_AW-1:0] mem_req_addr;
  logic [DATA_W-1:0] mem_req_wdata;
  logic              mem_rsp_valid;
  logic [DATA_W-1:0] mem_rsp_data;
  logic              fill_we;
  logic              unused_bits;

  always_comb begin
    off         = bus.Addr[OFF_MSB:OFF_LSB];
    idx         = bus.Addr[IDX_MSB:IDX_LSB];
    tag         = bus.Addr[TAG_MSB:TAG_LSB];
    req         = bus.Rd || bus.Wr;
    hit         = (state == S_IDLE) && valid[idx] && (tag_arr[idx] == tag) && req;
    line_word   = data_arr[idx][off];
    unused_bits = ^{bus.Addr[ADDR_W-1:TAG_MSB+1], bus.Addr[OFF_LSB-1:0], bus.createdump};
  end

  // Write-back uses the resident tag; fills use the requested one.
  always_comb begin
    mem_req_valid = (state == S_WB) || (state == S_FILL_REQ);
    mem_req_write = (state == S_WB);
    mem_req_addr  = word_addr((state == S_WB) ? tag_arr[idx] : tag, idx, cnt);
    mem_req_wdata = data_arr[idx][cnt];
    fill_we       = mem_rsp_valid && ((state == S_FILL_REQ) || (state == S_FILL_WAIT));
  end

  main_mem_model #(
    .LAT(LAT)
  ) u_mem (
    .clk       (clk),
    .rst       (rst),
    .req_valid (mem_req_valid),
    .req_write (mem_req_write),
    .req_addr  (mem_req_addr),
    .req_wdata (mem_req_wdata),
    .rsp_valid (mem_rsp_valid),
    .rsp_data  (mem_rsp_data)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_IDLE;
      cnt     <= '0;
      rsp_cnt <= '0;
      valid   <= '0;
      dirty   <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (req && !hit) begin
            state   <= dirty[idx] ? S_WB : S_FILL_REQ;
            cnt     <= '0;
            rsp_cnt <= '0;
          end else if (hit && bus.Wr) begin
            dirty[idx] <= 1'b1;
          end
        end
        S_WB: begin
          cnt <= cnt + 1'b1;
          if (cnt == LAST_WORD) state <= S_FILL_REQ;
        end
        // Early returns overlap the tail of the request burst.
        S_FILL_REQ: begin
          cnt <= cnt + 1'b1;
          if (mem_rsp_valid) rsp_cnt <= rsp_cnt + 1'b1;
          if (cnt == LAST_WORD) state <= S_FILL_WAIT;
        end
        S_FILL_WAIT: begin
          if (mem_rsp_valid) begin
            rsp_cnt <= rsp_cnt + 1'b1;
            if (rsp_cnt == LAST_WORD) state <= S_INSTALL;
          end
        end
        S_INSTALL: begin
          valid[idx] <= 1'b1;
          dirty[idx] <= bus.Wr;
          state      <= S_COMPLETE;
        end
        S_COMPLETE: state <= S_IDLE;
        default:    state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (fill_we) begin
      data_arr[idx][rsp_cnt] <= mem_rsp_data;
    end
    if (hit && bus.Wr) begin
      data_arr[idx][off] <= bus.DataIn;
    end
    if (state == S_INSTALL) begin
      tag_arr[idx] <= tag;
      if (bus.Wr) data_arr[idx][off] <= bus.DataIn;
    end
  end

  always_comb begin
    bus.Done     = 1'b0;
    bus.Stall    = 1'b0;
    bus.CacheHit = 1'b0;
    bus.DataOut  = '0;
    unique case (state)
      S_IDLE: begin
        if (hit) begin
          bus.Done     = 1'b1;
          bus.CacheHit = 1'b1;
          if (bus.Rd) bus.DataOut = line_word;
        end else if (req) begin
          bus.Stall = 1'b1;
        end
      end
      S_COMPLETE: begin
        bus.Done = 1'b1;
        if (bus.Rd) bus.DataOut = line_word;
      end
      default: bus.Stall = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_dm_cache_mem_system.sv
// Directed plus randomized load/store bench for dm_cache_mem_system, checked
// against a line-level write-back cache model over a flat golden memory.
module tb_dm_cache_mem_system;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  dm_cache_mem_system_if bus ();

  dm_cache_mem_system dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: flat memory plus which line each set holds.
  logic [31:0] m_mem  [65536];
  bit          m_valid[64];
  bit          m_dirty[64];
  int unsigned m_tag  [64];
  logic [31:0] m_line [64][4];

  task automatic check(input string nm, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", nm, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 64; i++) begin
      m_valid[i] = 1'b0;
      m_dirty[i] = 1'b0;
    end
  endtask

  task automatic model_access(input bit rd, input logic [31:0] addr, input logic [31:0] wd,
                              output logic [31:0] ed, output bit eh);
    int unsigned w, off, idx, tg;
    w   = int'(addr[17:2]);
    off = w % 4;
    idx = (w / 4) % 64;
    tg  = w / 256;
    eh  = m_valid[idx] && (m_tag[idx] == tg);
    if (!eh) begin
      if (m_valid[idx] && m_dirty[idx])
        for (int k = 0; k < 4; k++) m_mem[(m_tag[idx] * 64 + idx) * 4 + k] = m_line[idx][k];
      for (int k = 0; k < 4; k++) m_line[idx][k] = m_mem[(tg * 64 + idx) * 4 + k];
      m_valid[idx] = 1'b1;
      m_dirty[idx] = 1'b0;
      m_tag[idx]   = tg;
    end
    ed = '0;
    if (rd) begin
      ed = m_line[idx][off];
    end else begin
      m_line[idx][off] = wd;
      m_dirty[idx]     = 1'b1;
    end
  endtask

  task automatic do_access(input bit rd, input logic [31:0] addr, input logic [31:0] wd,
                           output logic [31:0] data, output logic hit, output int lat,
                           output bit seen, output bit proto_ok);
    @(negedge clk);
    bus.Addr   = addr;
    bus.DataIn = wd;
    bus.Rd     = rd;
    bus.Wr     = !rd;
    seen = 1'b0; proto_ok = 1'b1; lat = 0; data = '0; hit = 1'b0;
    for (int c = 0; c <= 40; c++) begin
      #1;
      if (bus.Done === 1'b1) begin
        seen = 1'b1;
        data = bus.DataOut;
        hit  = bus.CacheHit;
        lat  = c;
        if (bus.Stall !== 1'b0) proto_ok = 1'b0;
        break;
      end
      if (bus.Stall !== 1'b1 || bus.DataOut !== '0 || bus.CacheHit !== 1'b0) proto_ok = 1'b0;
      @(negedge clk);
    end
    @(negedge clk);
    bus.Rd = 1'b0;
    bus.Wr = 1'b0;
  endtask

  task automatic run(input bit rd, input logic [31:0] addr, input logic [31:0] wd,
                     input string nm, output int lat);
    logic [31:0] ed, data;
    bit          eh, seen, proto_ok;
    logic        hit;
    model_access(rd, addr, wd, ed, eh);
    do_access(rd, addr, wd, data, hit, lat, seen, proto_ok);
    check($sformatf("%s_done", nm), 32'(seen), 32'd1);
    if (seen) begin
      check($sformatf("%s_hit", nm), 32'(hit), 32'(eh));
      check($sformatf("%s_proto", nm), 32'(proto_ok), 32'd1);
      if (rd) check($sformatf("%s_data", nm), data, ed);
      if (eh) check($sformatf("%s_hitlat", nm), 32'(lat), 32'd0);
      else    check($sformatf("%s_misslat", nm), 32'((lat >= 3) && (lat <= 20)), 32'd1);
    end
  endtask

  initial begin
    int lat;
    n_checks = 0;
    n_fail   = 0;
    for (int i = 0; i < 65536; i++) m_mem[i] = '0;
    model_reset();
    bus.Addr = '0; bus.DataIn = '0; bus.Rd = 1'b0; bus.Wr = 1'b0; bus.createdump = 1'b0;

    rst = 1'b0;
    #3;
    check("rst_done",  32'(bus.Done),     32'd0);
    check("rst_stall", 32'(bus.Stall),    32'd0);
    check("rst_hit",   32'(bus.CacheHit), 32'd0);
    check("rst_data",  bus.DataOut,       32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    run(1'b1, 32'h0010, '0, "cold_rd", lat);
    check("cold_lat", 32'(lat), 32'd8);
    run(1'b1, 32'h0014, '0, "line_rd14", lat);
    run(1'b1, 32'h0018, '0, "line_rd18", lat);
    run(1'b1, 32'h001C, '0, "line_rd1c", lat);
    run(1'b0, 32'h0050, 32'hDEADBEEF, "alloc_wr", lat);
    run(1'b1, 32'h0050, '0, "alloc_rd", lat);

    #1;
    check("idle_done",  32'(bus.Done),  32'd0);
    check("idle_stall", 32'(bus.Stall), 32'd0);

    run(1'b0, 32'h0020, 32'h12345678, "evict_wr", lat);
    run(1'b1, 32'h0420, '0, "evict_rd", lat);
    check("evict_lat", 32'(lat), 32'd12);
    run(1'b1, 32'h0020, '0, "evict_back", lat);

    // Abort a clean miss while fill data is returning.
    @(negedge clk);
    bus.Addr = 32'h0810; bus.Rd = 1'b1;
    repeat (5) @(negedge clk);
    check("midmiss_stall", 32'(bus.Stall), 32'd1);
    #2;
    bus.Rd = 1'b0;
    rst    = 1'b0;
    model_reset();
    #1;
    check("midrst_done",  32'(bus.Done),     32'd0);
    check("midrst_stall", 32'(bus.Stall),    32'd0);
    check("midrst_hit",   32'(bus.CacheHit), 32'd0);
    check("midrst_data",  bus.DataOut,       32'd0);
    @(negedge clk);
    rst = 1'b1;
    run(1'b1, 32'h0810, '0, "after_rst", lat);
    run(1'b1, 32'h0050, '0, "lost_dirty", lat);
    run(1'b1, 32'h0020, '0, "kept_wb", lat);

    for (int n = 0; n < 1000; n++) begin
      bit          rd;
      logic [31:0] a, d;
      rd = 1'($urandom_range(0, 1));
      a  = 32'($urandom_range(0, 1023)) << 2;
      d  = $urandom;
      run(rd, a, d, $sformatf("rnd%0d", n), lat);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
